// File: rtl/commit_trace_pkg.sv
// Shared record type, drain states and word builders for the commit-trace drain path.
// Build option TRACE_TIMESTAMP_EN adds a cycle timestamp per record and a TS stream word.
package commit_trace_pkg;

  localparam logic [3:0] TRACE_SYNC    = 4'hC;
  localparam int         HDR_SYNC_LSB  = 28;
  localparam int         HDR_MEM_BIT   = 27;
  localparam int         HDR_RDV_BIT   = 26;
  localparam int         HDR_RADDR_LSB = 21;
  localparam int         HDR_TS_BIT    = 20;
`ifdef TRACE_TIMESTAMP_EN
  localparam logic       TS_PRESENT    = 1'b1;
`else
  localparam logic       TS_PRESENT    = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic        mem_wrt;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [15:0] seq;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] ts;
`endif
  } trace_rec_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR, ST_TS, ST_PC, ST_INSTR, ST_RDATA, ST_MADDR, ST_MDATA
  } drain_state_e;

  function automatic logic [31:0] trace_header(trace_rec_t r);
    logic [31:0] w;
    w                     = 32'h0;
    w[HDR_SYNC_LSB +: 4]  = TRACE_SYNC;
    w[HDR_MEM_BIT]        = r.mem_wrt;
    w[HDR_RDV_BIT]        = (r.reg_addr != 5'd0);
    w[HDR_RADDR_LSB +: 5] = r.reg_addr;
    w[HDR_TS_BIT]         = TS_PRESENT;
    w[15:0]               = r.seq;
    return w;
  endfunction

  // Word following s in this record; ST_IDLE means s was the last word.
  function automatic drain_state_e next_word(drain_state_e s, trace_rec_t r);
    drain_state_e n;
    case (s)
      ST_HDR:   n = TS_PRESENT ? ST_TS : ST_PC;
      ST_TS:    n = ST_PC;
      ST_PC:    n = ST_INSTR;
      ST_INSTR: n = (r.reg_addr != 5'd0) ? ST_RDATA : (r.mem_wrt ? ST_MADDR : ST_IDLE);
      ST_RDATA: n = r.mem_wrt ? ST_MADDR : ST_IDLE;
      ST_MADDR: n = ST_MDATA;
      default:  n = ST_IDLE;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] word_data(drain_state_e s, trace_rec_t r);
    logic [31:0] w;
    case (s)
      ST_HDR:   w = trace_header(r);
`ifdef TRACE_TIMESTAMP_EN
      ST_TS:    w = r.ts;
`endif
      ST_PC:    w = r.pc;
      ST_INSTR: w = r.instr;
      ST_RDATA: w = r.reg_data;
      ST_MADDR: w = r.mem_addr;
      ST_MDATA: w = r.mem_data;
      default:  w = 32'h0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/trace_record_fifo.sv
// Synchronous FIFO of trace records; head is read straight from storage, so a record
// pushed at one edge is first visible to the consumer in the following cycle.
module trace_record_fifo
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  trace_rec_t   push_data_i,
  input  logic         pop_i,
  output trace_rec_t   pop_data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  level_o
);

  trace_rec_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign full_o     = (level_q == (AW + 1)'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;

endmodule

// File: rtl/commit_trace_drain.sv
// Captures core commit records into a FIFO and drains them as 32-bit stream words.
// TRACE_TIMESTAMP_EN: adds a free-running cycle counter sampled into each record.
module commit_trace_drain
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int XLEN  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     update_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [XLEN-1:0]          instr_i,
  input  logic [4:0]               reg_addr_i,
  input  logic [XLEN-1:0]          reg_data_i,
  input  logic                     mem_wrt_i,
  input  logic [XLEN-1:0]          mem_addr_i,
  input  logic [XLEN-1:0]          mem_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [31:0]              out_data_o,
  output logic                     out_last_o,
  output logic                     overflow_o,
  output logic [15:0]              drop_cnt_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  trace_rec_t   rec_in;
  trace_rec_t   fifo_head;
  trace_rec_t   hold_q, hold_d;
  drain_state_e state_q, state_d;
  logic         fifo_full, fifo_empty, push, pop;
  logic [15:0]  seq_q, drop_cnt_q;
  logic         overflow_q;
  logic         out_valid_q, out_last_q;
  logic [31:0]  out_data_q;

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]  ts_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) ts_q <= '0;
    else       ts_q <= ts_q + 32'd1;
  end
`endif

  always_comb begin
    rec_in          = '0;
    rec_in.pc       = pc_i;
    rec_in.instr    = instr_i;
    rec_in.reg_addr = reg_addr_i;
    rec_in.reg_data = reg_data_i;
    rec_in.mem_wrt  = mem_wrt_i;
    rec_in.mem_addr = mem_addr_i;
    rec_in.mem_data = mem_data_i;
    rec_in.seq      = seq_q;
`ifdef TRACE_TIMESTAMP_EN
    rec_in.ts       = ts_q;
`endif
  end

  // A full FIFO still accepts a commit when the drain side frees a slot this cycle.
  assign push = update_i && (!fifo_full || pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seq_q      <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else if (push) begin
      seq_q <= seq_q + 16'd1;
    end else if (update_i) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  trace_record_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (rec_in),
    .pop_i       (pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level_o)
  );

  // Loading the next record on the last accepted word avoids an idle bubble between records.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    if (state_q == ST_IDLE || (out_valid_q && out_ready_i && out_last_q)) begin
      if (!fifo_empty) begin
        pop     = 1'b1;
        hold_d  = fifo_head;
        state_d = ST_HDR;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (out_valid_q && out_ready_i) begin
      state_d = next_word(state_q, hold_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      out_valid_q <= (state_d != ST_IDLE);
      out_data_q  <= word_data(state_d, hold_d);
      out_last_q  <= (state_d != ST_IDLE) && (next_word(state_d, hold_d) == ST_IDLE);
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule
